// File: rtl/instruction_sequencer.sv
// Instruction sequencer: owns the pc, fetches words from instruction memory
// over req/ack, and hands decoded opcode/register fields to the decoder over
// valid/ready. HALT and illegal opcodes are trapped here, so the decoder only
// ever sees opcodes 0000..0110.
module instruction_sequencer #(
  parameter int PC_W    = 5,
  parameter int REG_AW  = 5,
  parameter int INSTR_W = 19,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [3:0]         opcode,
  output logic [REG_AW-1:0]  ra1,
  output logic [REG_AW-1:0]  ra2,
  output logic [REG_AW-1:0]  wa,
  output logic [PC_W-1:0]    pc_out,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   issued_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t               state;
  state_t               state_nxt;
  logic [PC_W-1:0]      pc;
  logic [INSTR_W-1:0]   ir_p0;
  logic [3:0]           ir_op;

  // Opcodes 0000..0110 are the ones the decoder implements.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= 4'd6);
  endfunction

  assign ir_op  = ir_p0[INSTR_W-1 -: 4];
  assign pc_out = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs decoded from the state.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    imem_addr   = '0;
    issue_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (op_is_legal(ir_op))   state_nxt = S_ISSUE;
        else if (ir_op == OP_HALT) state_nxt = S_HALTED;
        else                       state_nxt = S_FETCH;
      end
      S_ISSUE: begin
        issue_valid = 1'b1;
        if (issue_ready) state_nxt = S_FETCH;
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: instruction register, issued fields, pc, sticky flags, counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      ir_p0        <= '0;
      opcode       <= '0;
      ra1          <= '0;
      ra2          <= '0;
      wa           <= '0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
      issued_count <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) ir_p0 <= imem_rdata;
        end
        S_DECODE: begin
          if (op_is_legal(ir_op)) begin
            opcode <= ir_op;
            ra1    <= ir_p0[3*REG_AW-1 -: REG_AW];
            ra2    <= ir_p0[2*REG_AW-1 -: REG_AW];
            wa     <= ir_p0[REG_AW-1:0];
          end else if (ir_op == OP_HALT) begin
            halted <= 1'b1;
          end else begin
            illegal <= 1'b1;
            pc      <= pc + PC_W'(1);
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            pc           <= pc + PC_W'(1);
            issued_count <= issued_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer; a small memory responder answers
// fetches with a programmable wait, everything else is driven step by step.
module tb_instruction_sequencer;
  localparam int PC_W    = 2;
  localparam int REG_AW  = 5;
  localparam int INSTR_W = 19;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               issue_valid;
  logic               issue_ready = 1'b0;
  logic [3:0]         opcode;
  logic [REG_AW-1:0]  ra1, ra2, wa;
  logic [PC_W-1:0]    pc_out;
  logic               halted, illegal;
  logic [CNT_W-1:0]   issued_count;

  int total = 0;
  int bad   = 0;

  logic [INSTR_W-1:0] mem [4];
  logic               ack_en = 1'b0;
  logic               manual_ack = 1'b0;
  logic [INSTR_W-1:0] manual_rdata = '0;
  int                 delay = 0;
  int                 wcnt = 0;

  instruction_sequencer #(
    .PC_W(PC_W), .REG_AW(REG_AW), .INSTR_W(INSTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .ra1(ra1), .ra2(ra2), .wa(wa), .pc_out(pc_out),
    .halted(halted), .illegal(illegal), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after 'delay' request cycles, or follows manual drive.
  always @(negedge clk) begin
    if (!ack_en) begin
      imem_ack   = manual_ack;
      imem_rdata = manual_rdata;
      wcnt       = 0;
    end else if (!imem_req) begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end else if (wcnt >= delay) begin
      imem_ack   = 1'b1;
      imem_rdata = mem[imem_addr];
      wcnt       = 0;
    end else begin
      imem_ack = 1'b0;
      wcnt++;
    end
  end

  function automatic logic [INSTR_W-1:0] instr(input logic [3:0] op, input logic [4:0] a,
                                               input logic [4:0] b, input logic [4:0] c);
    return {op, a, b, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 40 && !halted; i++) step();
    check("halt_reached", halted, 1);
  endtask

  initial begin
    // ---------------- reset mid-fetch ----------------
    do_reset();
    mem[0] = instr(4'b0101, 5'd1, 5'd2, 5'd3);
    mem[1] = mem[0];
    mem[2] = mem[0];
    mem[3] = mem[0];
    ack_en = 1'b1; delay = 0; issue_ready = 1'b1;
    start_pulse();
    for (int i = 0; i < 40 && !(pc_out == 2'd3 && imem_req); i++) step();
    ack_en = 1'b0;
    check("mid_fetch_pc", pc_out, 3);
    check("mid_fetch_req", imem_req, 1);
    check("mid_fetch_addr", imem_addr, 3);
    do_reset();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_pc", pc_out, 0);
    check("rst_valid", issue_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_count", issued_count, 0);
    check("rst_opcode", opcode, 0);
    check("rst_ra1", ra1, 0);
    check("rst_wa", wa, 0);
    manual_rdata = instr(4'b0010, 5'd1, 5'd2, 5'd3);
    manual_ack = 1'b1;
    step();
    manual_ack = 1'b0;
    check("late_ack_req", imem_req, 0);
    check("late_ack_valid", issue_valid, 0);
    step();
    check("late_ack_valid2", issue_valid, 0);
    check("late_ack_req2", imem_req, 0);

    // ---------------- straight-line program ----------------
    do_reset();
    mem[0] = instr(4'b0010, 5'd1, 5'd2, 5'd3);
    mem[1] = instr(4'b0011, 5'd4, 5'd5, 5'd6);
    mem[2] = instr(4'b1111, 5'd0, 5'd0, 5'd0);
    ack_en = 1'b1; delay = 0; issue_ready = 1'b1;
    start_pulse();
    check("sl_req0", imem_req, 1);
    check("sl_addr0", imem_addr, 0);
    step();
    check("sl_decode_valid", issue_valid, 0);
    step();
    check("sl_valid0", issue_valid, 1);
    check("sl_op0", opcode, 4'b0010);
    check("sl_ra1_0", ra1, 1);
    check("sl_ra2_0", ra2, 2);
    check("sl_wa_0", wa, 3);
    step();
    check("sl_valid_drop", issue_valid, 0);
    check("sl_pc1", pc_out, 1);
    check("sl_count1", issued_count, 1);
    step();
    step();
    check("sl_valid1", issue_valid, 1);
    check("sl_op1", opcode, 4'b0011);
    check("sl_wa_1", wa, 6);
    step();
    step();
    step();
    check("sl_halted", halted, 1);
    check("sl_halt_pc", pc_out, 2);
    check("sl_halt_count", issued_count, 2);
    check("sl_halt_req", imem_req, 0);

    // ---------------- memory latency and backpressure ----------------
    do_reset();
    mem[0] = instr(4'b0110, 5'd7, 5'd8, 5'd9);
    mem[1] = instr(4'b1111, 5'd0, 5'd0, 5'd0);
    ack_en = 1'b1; delay = 3; issue_ready = 1'b0;
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      check("bp_req_hold", imem_req, 1);
      check("bp_addr_hold", imem_addr, 0);
      step();
    end
    check("bp_decode_req", imem_req, 0);
    check("bp_decode_valid", issue_valid, 0);
    step();
    check("bp_valid", issue_valid, 1);
    check("bp_op", opcode, 4'b0110);
    check("bp_ra1", ra1, 7);
    check("bp_ra2", ra2, 8);
    check("bp_wa", wa, 9);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      check("bp_valid_hold", issue_valid, 1);
      check("bp_op_hold", opcode, 4'b0110);
      check("bp_pc_hold", pc_out, 0);
      check("bp_no_fetch", imem_req, 0);
    end
    issue_ready = 1'b1;
    delay = 0;
    step();
    check("bp_accept_valid", issue_valid, 0);
    check("bp_accept_pc", pc_out, 1);
    check("bp_accept_count", issued_count, 1);
    check("bp_refetch", imem_req, 1);
    wait_halt();
    check("bp_halt_pc", pc_out, 1);
    start_pulse();
    check("halted_start_req", imem_req, 0);
    check("halted_start_halted", halted, 1);
    check("halted_start_pc", pc_out, 1);
    step();
    check("halted_start_req2", imem_req, 0);

    // ---------------- illegal opcode ----------------
    do_reset();
    mem[0] = instr(4'b1001, 5'd1, 5'd1, 5'd1);
    mem[1] = instr(4'b0001, 5'd4, 5'd5, 5'd6);
    mem[2] = instr(4'b1111, 5'd0, 5'd0, 5'd0);
    ack_en = 1'b1; delay = 0; issue_ready = 1'b1;
    start_pulse();
    step();
    check("ill_decode_valid", issue_valid, 0);
    step();
    check("ill_flag", illegal, 1);
    check("ill_pc", pc_out, 1);
    check("ill_valid", issue_valid, 0);
    check("ill_count0", issued_count, 0);
    check("ill_refetch_addr", imem_addr, 1);
    step();
    step();
    check("ill_or_valid", issue_valid, 1);
    check("ill_or_op", opcode, 4'b0001);
    check("ill_or_ra1", ra1, 4);
    check("ill_or_pc", pc_out, 1);
    step();
    check("ill_count1", issued_count, 1);
    wait_halt();
    check("ill_sticky", illegal, 1);

    // ---------------- pc wrap ----------------
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = instr(4'b0100, 5'(i), 5'd2, 5'd3);
    ack_en = 1'b1; delay = 0; issue_ready = 1'b1;
    start_pulse();
    for (int k = 0; k < 4; k++) begin
      check("wrap_addr", imem_addr, k);
      check("wrap_req", imem_req, 1);
      if (k == 3) mem[0] = instr(4'b1111, 5'd0, 5'd0, 5'd0);
      step();
      step();
      check("wrap_ra1", ra1, k);
      step();
    end
    check("wrap_addr_back", imem_addr, 0);
    check("wrap_pc_back", pc_out, 0);
    step();
    step();
    check("wrap_halted", halted, 1);
    check("wrap_halt_pc", pc_out, 0);
    check("wrap_count", issued_count, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
